// File: rtl/interrupt_controller_pkg.sv
// Shared constants and types for the interrupt controller: register map,
// source limits and the bus handshake state encoding.
package interrupt_controller_pkg;

  localparam int MAX_SOURCES = 32;
  localparam int ID_WIDTH    = 6;

  localparam logic [3:0] IC_PENDING  = 4'h0;
  localparam logic [3:0] IC_ENABLE   = 4'h1;
  localparam logic [3:0] IC_CLAIM    = 4'h2;
  localparam logic [3:0] IC_COMPLETE = 4'h3;
  localparam logic [3:0] IC_RAW      = 4'h4;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACCESS,
    BUS_HOLD
  } bus_state_t;

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set bit of the masked pending
// vector as index+1, so an id of 0 always means "nothing to service".
module interrupt_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int SOURCES = 8
) (
  input  logic [SOURCES-1:0]  pending,
  output logic                valid,
  output logic [ID_WIDTH-1:0] id
);

  // Scan from the top down so the lowest index is the last one written and wins.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        valid = 1'b1;
        id    = ID_WIDTH'(i + 1);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-latched pending bits, enable mask, fixed-priority
// claim/complete handshake and a request/ready register slave.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int SOURCES = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [SOURCES-1:0] i_interrupt,
  input  logic               i_request,
  input  logic               i_rw,
  input  logic [3:0]         i_address,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_ready,
  output logic               o_interrupt
);

  bus_state_t          state;
  bus_state_t          next_state;
  logic                request_q;
  logic                start;
  logic                do_access;
  logic                ready_next;

  logic [SOURCES-1:0]  pending;
  logic [SOURCES-1:0]  enable;
  logic [SOURCES-1:0]  prev;
  logic                in_service;
  logic [ID_WIDTH-1:0] active_id;

  logic [SOURCES-1:0]  masked;
  logic [SOURCES-1:0]  set_mask;
  logic [SOURCES-1:0]  clear_mask;
  logic [SOURCES-1:0]  claim_mask;
  logic                claim_valid;
  logic [ID_WIDTH-1:0] claim_id;
  logic                do_read;
  logic                do_write;
  logic                do_claim;
  logic                do_complete;
  logic [31:0]         read_value;
  logic                unused_wdata;

  assign unused_wdata = ^i_wdata;
  assign start        = i_request && !request_q;
  assign masked       = pending & enable;

  interrupt_priority_encoder #(
    .SOURCES (SOURCES)
  ) u_priority_encoder (
    .pending (masked),
    .valid   (claim_valid),
    .id      (claim_id)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= BUS_IDLE;
      request_q <= 1'b0;
    end else begin
      state     <= next_state;
      request_q <= i_request;
    end
  end

  // The access happens one edge after the request rises; o_ready follows it.
  always_comb begin
    next_state = state;
    case (state)
      BUS_IDLE:   if (start) next_state = BUS_ACCESS;
      BUS_ACCESS: next_state = i_request ? BUS_HOLD : BUS_IDLE;
      BUS_HOLD:   if (!i_request) next_state = BUS_IDLE;
      default:    next_state = BUS_IDLE;
    endcase
  end

  always_comb begin
    do_access  = (state == BUS_ACCESS);
    ready_next = (next_state == BUS_HOLD);
  end

  assign do_read     = do_access && !i_rw;
  assign do_write    = do_access && i_rw;
  assign do_claim    = do_read && (i_address == IC_CLAIM) && claim_valid && !in_service;
  assign do_complete = do_write && (i_address == IC_COMPLETE) && in_service
                       && (i_wdata[ID_WIDTH-1:0] == active_id);

  always_comb begin
    claim_mask = '0;
    for (int i = 0; i < SOURCES; i++) begin
      claim_mask[i] = do_claim && (claim_id == ID_WIDTH'(i + 1));
    end
  end

  always_comb begin
    set_mask   = i_interrupt & ~prev;
    clear_mask = claim_mask;
    if (do_write && (i_address == IC_PENDING)) begin
      clear_mask = clear_mask | i_wdata[SOURCES-1:0];
    end
  end

  always_comb begin
    read_value = '0;
    case (i_address)
      IC_PENDING: read_value[SOURCES-1:0] = pending;
      IC_ENABLE:  read_value[SOURCES-1:0] = enable;
      IC_CLAIM:   if (claim_valid && !in_service) read_value[ID_WIDTH-1:0] = claim_id;
      IC_RAW:     read_value[SOURCES-1:0] = i_interrupt;
      default:    read_value = '0;
    endcase
  end

  // A new edge is OR-ed in after clearing so it survives a same-cycle clear.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pending    <= '0;
      enable     <= '0;
      prev       <= '0;
      in_service <= 1'b0;
      active_id  <= '0;
    end else begin
      pending <= (pending & ~clear_mask) | set_mask;
      prev    <= i_interrupt;
      if (do_write && (i_address == IC_ENABLE)) begin
        enable <= i_wdata[SOURCES-1:0];
      end
      if (do_claim) begin
        in_service <= 1'b1;
        active_id  <= claim_id;
      end else if (do_complete) begin
        in_service <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ready     <= 1'b0;
      o_rdata     <= '0;
      o_interrupt <= 1'b0;
    end else begin
      o_ready     <= ready_next;
      o_interrupt <= (|masked) && !in_service;
      if (do_access) begin
        o_rdata <= i_rw ? '0 : read_value;
      end else if (!ready_next) begin
        o_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: reads queue their expected data,
// a monitor checks o_rdata on every o_ready rise of a read.
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [7:0]  interrupt;
  logic        request;
  logic        rw;
  logic [3:0]  address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        cpu_irq;

  int          num_checks = 0;
  int          num_passed = 0;
  logic [31:0] exp_q[$];
  logic        last_ready = 1'b0;

  interrupt_controller #(
    .SOURCES (8)
  ) dut (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_interrupt (interrupt),
    .i_request   (request),
    .i_rw        (rw),
    .i_address   (address),
    .i_wdata     (wdata),
    .o_rdata     (rdata),
    .o_ready     (ready),
    .o_interrupt (cpu_irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    num_checks++;
    if (actual === expected) num_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic report_timeout(input string name);
    num_checks++;
    $display("[TB] FAIL %s: o_ready never rose, expected within 8 cycles", name);
  endtask

  // Monitor: every first cycle of o_ready on a read consumes one expectation.
  always @(negedge clock) begin
    if (ready && !last_ready && !rw) begin
      if (exp_q.size() == 0) check_output("unexpected_read", rdata, 32'hDEAD_BEEF);
      else check_output($sformatf("read_addr%0h", address), rdata, exp_q.pop_front());
    end
    last_ready = ready;
  end

  task automatic wait_ready(input string name);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clock);
      if (ready) seen = 1;
    end
    if (!seen) begin
      report_timeout(name);
      if (!rw && exp_q.size() != 0) void'(exp_q.pop_back());
    end
  endtask

  task automatic bus_transfer(input logic is_write, input logic [3:0] addr,
                              input logic [31:0] data, input logic [31:0] exp);
    @(posedge clock); #1;
    if (!is_write) exp_q.push_back(exp);
    request = 1'b1;
    rw      = is_write;
    address = addr;
    wdata   = data;
    wait_ready("bus_ready");
    @(posedge clock); #1;
    request = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp);
    bus_transfer(1'b0, addr, 32'h0, exp);
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    bus_transfer(1'b1, addr, data, 32'h0);
  endtask

  task automatic pulse_sources(input logic [7:0] mask);
    @(posedge clock); #1;
    interrupt = interrupt | mask;
    @(posedge clock); #1;
    interrupt = interrupt & ~mask;
  endtask

  initial begin
    int ready_count;
    reset_n   = 1'b0;
    interrupt = '0;
    request   = 1'b0;
    rw        = 1'b0;
    address   = '0;
    wdata     = '0;

    #12;
    check_output("reset_ready", 32'(ready), 32'h0);
    check_output("reset_irq", 32'(cpu_irq), 32'h0);
    check_output("reset_rdata", rdata, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Reset in the middle of a read transfer
    bus_write(IC_ENABLE, 32'h3);
    @(posedge clock); #1;
    exp_q.push_back(32'h3);
    request = 1'b1; rw = 1'b0; address = IC_ENABLE;
    wait_ready("midread_ready");
    #2 reset_n = 1'b0;
    #1;
    check_output("midreset_ready", 32'(ready), 32'h0);
    check_output("midreset_rdata", rdata, 32'h0);
    check_output("midreset_irq", 32'(cpu_irq), 32'h0);
    request = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus_read(IC_PENDING, 32'h0);
    bus_read(IC_ENABLE, 32'h0);

    // Basic flow with the timer on source 0
    bus_write(IC_ENABLE, 32'h1);
    @(posedge clock); #1;
    interrupt[0] = 1'b1;
    @(posedge clock); #1;
    interrupt[0] = 1'b0;
    @(negedge clock);
    check_output("latency_edge_n", 32'(cpu_irq), 32'h0);
    @(negedge clock);
    check_output("latency_edge_n1", 32'(cpu_irq), 32'h1);
    bus_read(IC_CLAIM, 32'h1);
    check_output("irq_after_claim", 32'(cpu_irq), 32'h0);
    bus_write(IC_COMPLETE, 32'h1);
    bus_read(IC_PENDING, 32'h0);
    check_output("irq_after_complete_empty", 32'(cpu_irq), 32'h0);

    // Priority: sources 5 and 2 together
    bus_write(IC_ENABLE, 32'hFF);
    pulse_sources(8'h24);
    repeat (2) @(negedge clock);
    check_output("irq_two_sources", 32'(cpu_irq), 32'h1);
    bus_read(IC_CLAIM, 32'h3);
    bus_read(IC_CLAIM, 32'h0);
    check_output("irq_in_service", 32'(cpu_irq), 32'h0);
    bus_write(IC_COMPLETE, 32'h3);
    check_output("irq_reassert", 32'(cpu_irq), 32'h1);
    bus_read(IC_CLAIM, 32'h6);
    bus_write(IC_COMPLETE, 32'h6);
    bus_read(IC_PENDING, 32'h0);

    // Masked level on source 1 latches once
    bus_write(IC_ENABLE, 32'h0);
    @(posedge clock); #1;
    interrupt[1] = 1'b1;
    repeat (10) @(posedge clock);
    bus_read(IC_PENDING, 32'h2);
    check_output("irq_masked", 32'(cpu_irq), 32'h0);
    bus_write(IC_ENABLE, 32'h2);
    check_output("irq_unmasked", 32'(cpu_irq), 32'h1);
    bus_read(IC_CLAIM, 32'h2);
    bus_write(IC_COMPLETE, 32'h2);
    bus_read(IC_PENDING, 32'h0);
    check_output("irq_level_no_relatch", 32'(cpu_irq), 32'h0);
    @(posedge clock); #1;
    interrupt[1] = 1'b0;

    // W1C colliding with a new edge on source 0
    pulse_sources(8'h01);
    @(posedge clock); #1;
    request = 1'b1; rw = 1'b1; address = IC_PENDING; wdata = 32'h1;
    @(posedge clock); #1;
    interrupt[0] = 1'b1;
    wait_ready("w1c_ready");
    @(posedge clock); #1;
    request = 1'b0;
    interrupt[0] = 1'b0;
    bus_read(IC_PENDING, 32'h1);
    bus_write(IC_PENDING, 32'h1);
    bus_read(IC_PENDING, 32'h0);

    // COMPLETE with the wrong id is ignored
    bus_write(IC_ENABLE, 32'h1);
    pulse_sources(8'h01);
    bus_read(IC_CLAIM, 32'h1);
    bus_write(IC_COMPLETE, 32'h4);
    pulse_sources(8'h01);
    repeat (2) @(negedge clock);
    check_output("irq_wrong_complete", 32'(cpu_irq), 32'h0);
    bus_read(IC_CLAIM, 32'h0);
    bus_write(IC_COMPLETE, 32'h1);
    check_output("irq_right_complete", 32'(cpu_irq), 32'h1);
    bus_read(IC_CLAIM, 32'h1);
    bus_write(IC_COMPLETE, 32'h1);

    // Long request on CLAIM: one access, four ready cycles
    bus_write(IC_ENABLE, 32'hC);
    pulse_sources(8'h0C);
    @(posedge clock); #1;
    exp_q.push_back(32'h3);
    request = 1'b1; rw = 1'b0; address = IC_CLAIM;
    ready_count = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      if (i == 5) request = 1'b0;
      @(negedge clock);
      if (ready) ready_count++;
    end
    check_output("ready_cycles", 32'(ready_count), 32'h4);
    bus_write(IC_COMPLETE, 32'h3);
    bus_read(IC_PENDING, 32'h8);
    bus_read(IC_CLAIM, 32'h4);
    bus_write(IC_COMPLETE, 32'h4);
    bus_read(4'h9, 32'h0);
    bus_write(4'h9, 32'hFFFF_FFFF);
    bus_read(IC_ENABLE, 32'hC);
    bus_read(IC_COMPLETE, 32'h0);

    // RAW reflects live inputs
    @(posedge clock); #1;
    interrupt = 8'hA0;
    bus_read(IC_RAW, 32'hA0);
    bus_read(IC_PENDING, 32'hA0);

    repeat (2) @(posedge clock);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Aggregates up to 32 level/pulse interrupt sources (the millisecond/compare/countdown timer's `o_interrupt` is source 0) into one CPU interrupt line. It latches rising edges into a pending register and masks them with an enable register. It arbitrates by fixed priority, lowest index first, through a claim/complete handshake. It sits between peripheral interrupt outputs and the CPU core and exposes a memory-mapped register slave on the same request/ready bus as the other peripherals.

## Interface
- `SOURCES`, default 8: number of interrupt inputs, 1..32.
- `i_clock`  in  1  system clock; all logic on its rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_interrupt`  in  SOURCES  source lines, synchronous to `i_clock`; bit 0 is the timer.
- `i_request`  in  1  bus request, held until `o_ready` is seen.
- `i_rw`  in  1  0 = read, 1 = write.
- `i_address`  in  4  word register index.
- `i_wdata`  in  32  write data.
- `o_rdata`  out  32  read data, valid while `o_ready` = 1.
- `o_ready`  out  1  transfer acknowledge.
- `o_interrupt`  out  1  interrupt request to CPU.

## Operation
- Registers, unused upper bits read 0:
  - 0x0 PENDING: read; write-1-to-clear.
  - 0x1 ENABLE: read/write.
  - 0x2 CLAIM: read only.
  - 0x3 COMPLETE: write only, reads 0.
  - 0x4 RAW: read; live `i_interrupt` sampled at the request cycle.
  - Other addresses: reads return 0, writes are ignored.
- Edge detect: `prev` register holds last cycle's `i_interrupt`. `i_interrupt & ~prev` sets PENDING bits. A held-high level sets pending once only.
- Pending is independent of ENABLE. Masked sources still latch.
- CLAIM read:
  - Returns id = index+1 of the lowest-indexed bit of PENDING & ENABLE, or 0 if none.
  - On nonzero id: clears that PENDING bit, sets `in_service` = 1 and stores `active_id`.
  - Reading CLAIM while `in_service` = 1 returns 0 and has no side effects (no nesting).
- COMPLETE write:
  - If `i_wdata[5:0]` == `active_id` and `in_service` = 1, clears `in_service`.
  - Otherwise ignored.
- `o_interrupt` is registered: next = |(PENDING & ENABLE) && !`in_service`.
- Priority rule: same-cycle set (new edge) beats clear (W1C or claim) for the same bit.
- Reset: asynchronous, clears everything.
  - PENDING, ENABLE, `prev`, `in_service`, `active_id` = 0.
  - `o_rdata` = 0, `o_ready` = 0, `o_interrupt` = 0.
  - Request-edge register = 0.
  - Reset mid-transfer aborts it. The master must drop and re-raise `i_request`.

## Timing
- Bus handshake:
  - A transfer starts on a rising edge of `i_request` (`i_request` && !`request_q`).
  - `o_ready` rises on the following clock edge, with `o_rdata` valid at the same time.
  - `o_ready` stays high while `i_request` is held, and falls the cycle after `i_request` drops.
  - One access per request pulse. Read side effects (CLAIM) occur exactly once.
- Interrupt latency:
  - Source rises in cycle N (sampled at edge N).
  - PENDING bit is set at edge N.
  - `o_interrupt` goes high at edge N+1.
- After a CLAIM: `o_interrupt` drops at the edge after the claim edge, whatever other pending bits remain.
- After COMPLETE: `o_interrupt` re-asserts one edge after the complete edge if any PENDING & ENABLE bit remains.
- ENABLE write: takes effect on `o_interrupt` one edge after the write edge.

## Structure
- Package `interrupt_controller_pkg` holds:
  - Address constants `IC_PENDING`, `IC_ENABLE`, `IC_CLAIM`, `IC_COMPLETE`, `IC_RAW`.
  - `MAX_SOURCES = 32`.
  - Id width constant (6 bits).
- Sub-module `interrupt_priority_encoder`:
  - Combinational, parameterised by `SOURCES`.
  - Input: masked pending vector. Outputs: `valid` and the index+1 id.
- Top level holds the registers, edge detect, bus FSM and in-service state.

## Test plan
- Reset/idle: assert `i_reset_n` = 0 mid-read -> all outputs 0 immediately; after release, PENDING reads 0x0 and ENABLE reads 0x0.
- Basic flow, timer as source 0:
  - Write ENABLE = 0x1, then pulse `i_interrupt[0]` one cycle -> `o_interrupt` = 1 two edges after the rise.
  - CLAIM reads 1; `o_interrupt` falls.
  - COMPLETE writes 1; PENDING reads 0.
- Priority:
  - ENABLE = 0xFF, edges on sources 5 and 2 in the same cycle.
  - CLAIM -> 3; second CLAIM before COMPLETE -> 0.
  - After COMPLETE(3), `o_interrupt` re-asserts and CLAIM -> 6.
- Mask and level:
  - ENABLE = 0, hold source 1 high for 10 cycles -> PENDING = 0x2, `o_interrupt` = 0.
  - Then ENABLE = 0x2 -> `o_interrupt` = 1 one edge later; pending was set only once.
- Collisions:
  - W1C PENDING = 0x1 in the same cycle as a new edge on source 0 -> PENDING still 0x1.
  - COMPLETE with the wrong id (e.g. 4 while active = 1) -> ignored; `in_service` remains 1.
- Handshake: hold `i_request` high for 5 cycles on a CLAIM read -> `o_ready` high 4 cycles, only one pending bit cleared; unmapped address 0x9 reads 0.
